// File: rtl/memresp_pkg.sv
// Shared types and default sizing for the data memory responder.
// MEMRESP_TIMEOUT_EN enables the RUN watchdog (TIMEOUT_CYCLES).
package memresp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DUMP
  } state_e;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 65536;
  localparam int DEF_LOAD_BASE = 0;
  localparam int DEF_LOAD_LEN  = 16384;
  localparam int DEF_DUMP_BASE = 16384;
  localparam int DEF_DUMP_LEN  = 4096;
  localparam int DEF_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/sp_byte_ram.sv
// Single-port byte RAM, registered read, read-before-write.
// Addresses at or above DEPTH drop writes and read back as zero.
module sp_byte_ram #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              hit;
  logic [IW-1:0]     idx;

  assign hit = 32'(addr) < 32'(DEPTH);
  assign idx = addr[IW-1:0];

  always_ff @(posedge clk) begin
    if (we && hit) mem[idx] <= wdata;
  end

  // Only the read register resets, so the port output is 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= hit ? mem[idx] : '0;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Job sequencer and image RAM owner for the downsample processor.
// MEMRESP_TIMEOUT_EN adds the RUN watchdog and timeout_err.
module data_mem_responder
  import memresp_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LOAD_BASE = DEF_LOAD_BASE,
  parameter int LOAD_LEN  = DEF_LOAD_LEN,
  parameter int DUMP_BASE = DEF_DUMP_BASE,
  parameter int DUMP_LEN  = DEF_DUMP_LEN
`ifdef MEMRESP_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_load,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              proc_run,
  input  logic              proc_wr,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic [DATA_W-1:0] proc_rdata,
  input  logic              proc_finished,
  output logic              dump_valid,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  input  logic              dump_ready,
  output logic              busy,
  output logic              job_done,
  output logic              timeout_err
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_LEN - 1);
  localparam logic [CW-1:0] DUMP_LAST = CW'(DUMP_LEN - 1);
  localparam logic [CW-1:0] DUMP_N    = CW'(DUMP_LEN);
  localparam logic [ADDR_W-1:0] LBASE = ADDR_W'(LOAD_BASE);
  localparam logic [ADDR_W-1:0] DBASE = ADDR_W'(DUMP_BASE);

  state_e            state;
  logic [ADDR_W-1:0] ptr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     beat;
  logic              rd_pend;
  logic [1:0]        occ;
  logic [DATA_W-1:0] buf0;
  logic [DATA_W-1:0] buf1;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic load_fire;
  logic pop;
  logic room;
  logic issue;
  logic to_hit;

  assign load_ready = state == ST_LOAD;
  assign load_fire  = load_ready && load_valid;
  assign proc_run   = state == ST_RUN;
  assign busy       = state != ST_IDLE;
  assign proc_rdata = ram_rdata;

  assign dump_valid = occ != 2'd0;
  assign dump_data  = buf0;
  assign dump_last  = dump_valid && (beat == DUMP_LAST);
  assign pop        = dump_valid && dump_ready;

  // Issue a read only if its data is sure to find a free slot.
  assign room  = ({1'b0, occ} + {2'b0, rd_pend})
              <= ({2'b0, pop} + 3'd1);
  assign issue = (state == ST_DUMP) && (cnt != DUMP_N) && room;

  always_comb begin
    ram_addr  = ptr;
    ram_we    = 1'b0;
    ram_wdata = load_data;
    unique case (1'b1)
      state == ST_LOAD: ram_we = load_valid;
      state == ST_RUN: begin
        ram_addr  = proc_addr;
        ram_we    = proc_wr;
        ram_wdata = proc_wdata;
      end
      default: ;
    endcase
  end

  sp_byte_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

`ifdef MEMRESP_TIMEOUT_EN
  logic [31:0] run_cyc;
  logic        tmo_q;

  assign to_hit = (state == ST_RUN) && !proc_finished
               && (run_cyc == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cyc <= '0;
      tmo_q   <= 1'b0;
    end else begin
      run_cyc <= (state == ST_RUN) ? run_cyc + 32'd1 : '0;
      if (state == ST_IDLE && cmd_load) tmo_q <= 1'b0;
      else if (to_hit)                  tmo_q <= 1'b1;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      cnt      <= '0;
      beat     <= '0;
      rd_pend  <= 1'b0;
      job_done <= 1'b0;
    end else begin
      job_done <= 1'b0;
      rd_pend  <= issue;
      case (state)
        ST_IDLE: if (cmd_load) begin
          state <= ST_LOAD;
          ptr   <= LBASE;
          cnt   <= '0;
        end
        ST_LOAD: if (load_fire) begin
          ptr <= ptr + ADDR_W'(1);
          cnt <= cnt + CW'(1);
          if (cnt == LOAD_LAST) state <= ST_RUN;
        end
        ST_RUN: if (proc_finished || to_hit) begin
          state <= ST_DUMP;
          ptr   <= DBASE;
          cnt   <= '0;
          beat  <= '0;
        end
        ST_DUMP: begin
          if (issue) begin
            ptr <= ptr + ADDR_W'(1);
            cnt <= cnt + CW'(1);
          end
          if (pop) begin
            beat <= beat + CW'(1);
            if (dump_last) begin
              state    <= ST_IDLE;
              job_done <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // buf0 is the presented beat, buf1 the skid slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      unique case ({rd_pend, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= ram_rdata;
          else             buf1 <= ram_rdata;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            buf0 <= buf1;
            buf1 <= ram_rdata;
          end else begin
            buf0 <= ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the downsample processor's data port: serves the processor's byte read/write bus (wr, 16-bit address, 8-bit write data, 8-bit read data).
- Owns the image RAM.
- Sequences a whole job: host streams the source image in, the processor runs, then the result is streamed back out once the processor raises finished.

Parameters:
- ADDR_W, 16, processor data address width
- DATA_W, 8, byte width
- DEPTH, 65536, RAM words; addresses >= DEPTH are unmapped
- LOAD_BASE, 0, first RAM address written by the load stream
- LOAD_LEN, 16384, bytes per load (128x128 image); must be >= 1
- DUMP_BASE, 16384, first RAM address read by the dump stream
- DUMP_LEN, 4096, bytes per dump (64x64 result); must be >= 1
- TIMEOUT_CYCLES, 1000000, RUN watchdog limit (optional feature only)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_load  in  1  single-cycle pulse, starts a job (honoured in IDLE only)
- load_valid  in  1  load byte valid
- load_data  in  DATA_W  load byte
- load_ready  out  1  responder accepts a load byte
- proc_run  out  1  processor permitted to execute (its clock gate/enable)
- proc_wr  in  1  processor write strobe
- proc_addr  in  ADDR_W  processor data address
- proc_wdata  in  DATA_W  processor write data
- proc_rdata  out  DATA_W  read data to processor
- proc_finished  in  1  processor halt flag
- dump_valid  out  1  result byte valid
- dump_data  out  DATA_W  result byte
- dump_last  out  1  marks final result byte
- dump_ready  in  1  host accepts result byte
- busy  out  1  state != IDLE
- job_done  out  1  one-cycle pulse after final dump beat
- timeout_err  out  1  sticky watchdog flag; 0 when feature is off

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs are 0, including proc_rdata and timeout_err.
  - Pointers and counters are cleared.
  - RAM contents are not cleared.
  - Reset mid-job aborts the job; a partial load or dump is discarded.
- IDLE:
  - cmd_load=1 -> LOAD; ptr=LOAD_BASE, cnt=0.
  - Load/dump handshakes are inactive.
  - proc_* inputs are ignored.
- LOAD:
  - load_ready=1.
  - Each cycle with load_valid & load_ready: RAM[ptr]=load_data, ptr++, cnt++.
  - On the beat where cnt reaches LOAD_LEN -> RUN next cycle.
  - cmd_load is ignored.
- RUN:
  - proc_run=1.
  - proc_wr=1 at a clock edge writes RAM[proc_addr]=proc_wdata.
  - proc_rdata=RAM[proc_addr] registered, 1-cycle latency, every RUN cycle (read-before-write on the same address).
  - proc_finished sampled 1 -> DUMP next cycle; proc_run drops in the same transition.
  - A write in the finishing cycle is still performed.
- DUMP:
  - ptr=DUMP_BASE, cnt=0; one-cycle RAM prefetch, so dump_valid rises 2 cycles after entry.
  - dump_data/dump_valid/dump_last hold stable while dump_valid & !dump_ready.
  - Next byte is presented the cycle after acceptance: 1 prefetch register plus a 1-deep skid, so there are no bubbles with ready held high.
  - dump_last=1 on beat DUMP_LEN-1.
  - Acceptance of the last beat -> IDLE and job_done=1 for one cycle.
- Addressing:
  - Pointers are ADDR_W bits and wrap modulo 2^ADDR_W.
  - Counters are ADDR_W+1 bits, so LEN=65536 is legal.
  - Addresses >= DEPTH: writes dropped, reads return 0.
- Simultaneous events:
  - One RAM port; states are mutually exclusive, so there is no arbitration.
  - Inputs belonging to an inactive state are ignored (load_valid outside LOAD, proc_wr outside RUN, dump_ready outside DUMP).

Optional Feature:
- Macro: MEMRESP_TIMEOUT_EN.
- Defined:
  - A RUN cycle counter reaching TIMEOUT_CYCLES without proc_finished forces DUMP and sets timeout_err=1.
  - timeout_err stays set until the next cmd_load or reset.
- Undefined:
  - No counter; timeout_err is tied 0; RUN waits indefinitely.

Decomposition:
- Shared package memresp_pkg holds:
  - state enum {IDLE, LOAD, RUN, DUMP}
  - default parameter constants
  - TIMEOUT_CYCLES default
- Sub-module sp_byte_ram:
  - synchronous single-port RAM with parameters DATA_W and DEPTH
  - registered read, 1-cycle latency
  - the FSM muxes its address, data and write-enable per state

Test Plan:
- Load a ramp (byte i = i mod 256) with LOAD_LEN=16384 and load_valid constant -> load_ready drops after beat 16383; proc_run rises the next cycle; RAM[0..16383] matches the ramp.
- In RUN, proc_addr=0x0005 -> proc_rdata=0x05 one cycle later. Then proc_wr=1, addr=0x4000, wdata=0xA5, then a read of 0x4000 -> 0xA5.
- Processor writes 0x4000..0x4FFF with value (addr & 0xFF) then raises finished -> 4096 dump beats 0x00..0xFF repeating; dump_last only on beat 4095; job_done pulses once; busy=0 afterwards.
- dump_ready toggled randomly, including 5-cycle stalls -> dump_data stable during stalls, no byte lost or duplicated.
- rst_n pulsed low mid-LOAD at beat 100 -> outputs 0 immediately; state IDLE; new cmd_load restarts from LOAD_BASE.
- With MEMRESP_TIMEOUT_EN and TIMEOUT_CYCLES=50, proc_finished held 0 -> DUMP entered after 50 RUN cycles; timeout_err=1 until the next cmd_load.
